// File: rtl/game_phase_fsm.sv
// Top-level game phase controller: latches event pulses between frames and
// commits phase/lives changes only at frame start so screens never tear.
module game_phase_fsm #(
  parameter int LIVES          = 3,
  parameter int TIMEOUT_CYCLES = 130000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [10:0] hcount_in,
  input  logic [9:0]  vcount_in,
  input  logic        start_btn_in,
  input  logic        pause_btn_in,
  input  logic        player_dead_in,
  input  logic        finished_in,
  output logic [3:0]  state_out,
  output logic [1:0]  lives_out,
  output logic        frame_start_out
);

  localparam int              WD_W       = $clog2(TIMEOUT_CYCLES);
  localparam logic [WD_W-1:0] WD_LAST    = WD_W'(TIMEOUT_CYCLES - 1);
  localparam logic [1:0]      LIVES_INIT = 2'(LIVES);

  typedef enum logic [3:0] {
    TITLE     = 4'b0001,
    PLAYING   = 4'b0010,
    PAUSED    = 4'b0011,
    GAME_OVER = 4'b1111
  } phase_t;

  phase_t            state;
  logic [1:0]        lives;
  logic              frame_start;
  logic              start_p, pause_p, dead_p;
  logic              exit_flag;
  logic [WD_W-1:0]   wd;

  logic boundary;
  logic start_m, pause_m, dead_m;

  assign boundary = (hcount_in == 11'd0) && (vcount_in == 10'd0);

  // Pulses landing in the boundary cycle itself are folded into this frame's decision.
  assign start_m = start_p | start_btn_in;
  assign pause_m = pause_p | pause_btn_in;
  assign dead_m  = dead_p  | player_dead_in;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= TITLE;
      lives       <= LIVES_INIT;
      frame_start <= 1'b0;
      start_p     <= 1'b0;
      pause_p     <= 1'b0;
      dead_p      <= 1'b0;
      exit_flag   <= 1'b0;
      wd          <= '0;
    end else begin
      frame_start <= boundary;

      if (boundary) begin
        start_p <= 1'b0;
        pause_p <= 1'b0;
        dead_p  <= 1'b0;
      end else begin
        start_p <= start_m;
        pause_p <= pause_m;
        dead_p  <= dead_m;
      end

      // Watchdog and finished_in both only ever set the one exit flag, so coincident sources exit once.
      if (state != GAME_OVER) begin
        wd        <= '0;
        exit_flag <= 1'b0;
      end else begin
        if (wd == WD_LAST) begin
          exit_flag <= 1'b1;
        end else begin
          wd <= wd + WD_W'(1);
        end
        if (finished_in) begin
          exit_flag <= 1'b1;
        end
      end

      if (boundary) begin
        case (state)
          TITLE: begin
            if (start_m) begin
              state <= PLAYING;
              lives <= LIVES_INIT;
            end
          end
          PLAYING: begin
            if (dead_m) begin
              if (lives > 2'd1) begin
                lives <= lives - 2'd1;
              end else begin
                state <= GAME_OVER;
                lives <= 2'd0;
              end
            end else if (pause_m) begin
              state <= PAUSED;
            end
          end
          PAUSED: begin
            if (pause_m) begin
              state <= PLAYING;
            end
          end
          GAME_OVER: begin
            if (exit_flag) begin
              state     <= TITLE;
              lives     <= LIVES_INIT;
              exit_flag <= 1'b0;
              wd        <= '0;
            end
          end
          default: begin
            state <= TITLE;
          end
        endcase
      end
    end
  end

  assign state_out       = state;
  assign lives_out       = lives;
  assign frame_start_out = frame_start;

endmodule

// File: tb/tb_game_phase_fsm.sv
// Directed bench for game_phase_fsm with a short watchdog; each step drives one
// clock cycle of inputs and checks the registered outputs one edge later.
module tb_game_phase_fsm;

  localparam logic [3:0] S_TITLE = 4'b0001;
  localparam logic [3:0] S_PLAY  = 4'b0010;
  localparam logic [3:0] S_PAUSE = 4'b0011;
  localparam logic [3:0] S_OVER  = 4'b1111;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [10:0] hcount_in = 11'd500;
  logic [9:0]  vcount_in = 10'd300;
  logic        start_btn_in = 1'b0;
  logic        pause_btn_in = 1'b0;
  logic        player_dead_in = 1'b0;
  logic        finished_in = 1'b0;
  logic [3:0]  state_out;
  logic [1:0]  lives_out;
  logic        frame_start_out;

  int n_checks = 0;
  int n_fail   = 0;

  game_phase_fsm #(.LIVES(3), .TIMEOUT_CYCLES(20)) dut (
    .clk             (clk),
    .rst             (rst),
    .hcount_in       (hcount_in),
    .vcount_in       (vcount_in),
    .start_btn_in    (start_btn_in),
    .pause_btn_in    (pause_btn_in),
    .player_dead_in  (player_dead_in),
    .finished_in     (finished_in),
    .state_out       (state_out),
    .lives_out       (lives_out),
    .frame_start_out (frame_start_out)
  );

  always #5 clk = ~clk;

  // Drive one cycle of inputs, then land 1 time unit after the edge that consumed them.
  task automatic applyStimulus(input logic bnd, input logic s, input logic p,
                               input logic d, input logic f);
    hcount_in      = bnd ? 11'd0 : 11'd500;
    vcount_in      = bnd ? 10'd0 : 10'd300;
    start_btn_in   = s;
    pause_btn_in   = p;
    player_dead_in = d;
    finished_in    = f;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [3:0] exp_state,
                             input logic [1:0] exp_lives, input logic exp_fs);
    n_checks++;
    assert (state_out === exp_state) else begin
      n_fail++;
      $error("[TB] FAIL %s state_out observed=%b expected=%b", tag, state_out, exp_state);
    end
    n_checks++;
    assert (lives_out === exp_lives) else begin
      n_fail++;
      $error("[TB] FAIL %s lives_out observed=%0d expected=%0d", tag, lives_out, exp_lives);
    end
    n_checks++;
    assert (frame_start_out === exp_fs) else begin
      n_fail++;
      $error("[TB] FAIL %s frame_start_out observed=%b expected=%b", tag, frame_start_out, exp_fs);
    end
  endtask

  // From PLAYING with 3 lives, one death per frame ends in GAME_OVER.
  task automatic playToGameOver(input string tag);
    applyStimulus(0, 0, 0, 1, 0);
    applyStimulus(1, 0, 0, 0, 0);
    checkOutput({tag, "_death1"}, S_PLAY, 2'd2, 1'b1);
    applyStimulus(0, 0, 0, 1, 0);
    applyStimulus(1, 0, 0, 0, 0);
    checkOutput({tag, "_death2"}, S_PLAY, 2'd1, 1'b1);
    applyStimulus(0, 0, 0, 1, 0);
    applyStimulus(1, 0, 0, 0, 0);
    checkOutput({tag, "_death3"}, S_OVER, 2'd0, 1'b1);
  endtask

  // Called right after GAME_OVER entry (GAME_OVER cycle 0 is the next one driven).
  task automatic watchdogExit(input string tag);
    for (int c = 0; c < 17; c++) applyStimulus(0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0);
    checkOutput({tag, "_early_bnd"}, S_OVER, 2'd0, 1'b1);
    for (int c = 18; c < 25; c++) applyStimulus(0, 0, 0, 0, 0);
    checkOutput({tag, "_expired_wait"}, S_OVER, 2'd0, 1'b0);
    applyStimulus(1, 0, 0, 0, 0);
    checkOutput({tag, "_exit"}, S_TITLE, 2'd3, 1'b1);
  endtask

  initial begin
    rst = 1'b1;
    applyStimulus(0, 0, 0, 0, 0);
    applyStimulus(1, 1, 0, 0, 0);
    checkOutput("reset", S_TITLE, 2'd3, 1'b0);
    rst = 1'b0;

    applyStimulus(0, 1, 0, 0, 0);
    checkOutput("start_midframe", S_TITLE, 2'd3, 1'b0);
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("start_pending", S_TITLE, 2'd3, 1'b0);
    applyStimulus(1, 0, 0, 0, 0);
    checkOutput("start_commit", S_PLAY, 2'd3, 1'b1);
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("fs_one_cycle", S_PLAY, 2'd3, 1'b0);

    applyStimulus(0, 0, 0, 1, 0);
    applyStimulus(0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 1, 0);
    applyStimulus(1, 0, 0, 0, 0);
    checkOutput("double_dead", S_PLAY, 2'd2, 1'b1);

    applyStimulus(0, 0, 0, 1, 0);
    applyStimulus(0, 0, 1, 0, 0);
    applyStimulus(1, 0, 0, 0, 0);
    checkOutput("dead_over_pause", S_PLAY, 2'd1, 1'b1);

    applyStimulus(0, 0, 1, 0, 0);
    applyStimulus(1, 0, 0, 0, 0);
    checkOutput("pause", S_PAUSE, 2'd1, 1'b1);
    applyStimulus(0, 1, 0, 1, 0);
    applyStimulus(1, 0, 0, 0, 0);
    checkOutput("dead_while_paused", S_PAUSE, 2'd1, 1'b1);
    applyStimulus(0, 0, 1, 0, 0);
    applyStimulus(1, 0, 0, 0, 0);
    checkOutput("unpause", S_PLAY, 2'd1, 1'b1);

    applyStimulus(0, 0, 0, 1, 0);
    applyStimulus(1, 0, 0, 0, 0);
    checkOutput("last_life", S_OVER, 2'd0, 1'b1);

    for (int c = 0; c < 5; c++) applyStimulus(0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 1);
    checkOutput("finished_not_immediate", S_OVER, 2'd0, 1'b0);
    applyStimulus(0, 1, 1, 1, 0);
    applyStimulus(1, 0, 0, 0, 0);
    checkOutput("finished_exit", S_TITLE, 2'd3, 1'b1);

    applyStimulus(0, 0, 0, 0, 1);
    applyStimulus(1, 0, 0, 0, 0);
    checkOutput("finished_in_title", S_TITLE, 2'd3, 1'b1);

    applyStimulus(1, 1, 0, 0, 0);
    checkOutput("start_on_boundary", S_PLAY, 2'd3, 1'b1);

    playToGameOver("go_a");
    watchdogExit("wd_a");

    applyStimulus(1, 1, 0, 0, 0);
    checkOutput("restart", S_PLAY, 2'd3, 1'b1);
    playToGameOver("go_b");
    for (int c = 0; c < 10; c++) applyStimulus(0, 0, 0, 0, 0);
    rst = 1'b1;
    applyStimulus(1, 1, 0, 0, 1);
    checkOutput("reset_in_gameover", S_TITLE, 2'd3, 1'b0);
    rst = 1'b0;

    applyStimulus(1, 1, 0, 0, 0);
    checkOutput("start_after_reset", S_PLAY, 2'd3, 1'b1);
    playToGameOver("go_c");
    watchdogExit("wd_c");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
